// File: rtl/pkt_drain_arbiter_pkg.sv
// Shared definitions for the packet drain arbiter.
// Holds the FSM state type, the "no grant" code, the port count, the header
// length-field position and the round-robin step helper.
package pkt_drain_arbiter_pkg;

  localparam int unsigned N_PORTS    = 3;
  localparam logic [1:0]  GRANT_NONE = 2'b11;
  localparam int unsigned LEN_MSB    = 7;
  localparam int unsigned LEN_LSB    = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRdHdr,
    StRdBody,
    StFlush,
    StAbort
  } state_e;

  // Port index 'step' positions after 'base', wrapping over N_PORTS.
  function automatic logic [1:0] rr_next(logic [1:0] base, int unsigned step);
    int unsigned sum;
    sum = 32'(base) + step;
    return 2'(sum % N_PORTS);
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-request round-robin arbiter.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   req_i           request per port
//   update_i        load update_idx_i as the last-served port
//   update_idx_i    port that was just served
//   gnt_vld_o       some request is present
//   gnt_idx_o       winning port, GRANT_NONE when no request
module rr_arbiter3
  import pkt_drain_arbiter_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_PORTS-1:0] req_i,
  input  logic               update_i,
  input  logic [1:0]         update_idx_i,
  output logic               gnt_vld_o,
  output logic [1:0]         gnt_idx_o
);

  logic [1:0] last_q;
  logic [3:0] req_pad;

  assign req_pad = {1'b0, req_i};

  // Reset to port 2 so that port 0 is first in line.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= 2'd2;
    end else if (update_i) begin
      last_q <= update_idx_i;
    end
  end

  // Scan from the far end so the nearest requester after last_q wins.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = GRANT_NONE;
    for (int unsigned k = N_PORTS; k >= 1; k--) begin
      if (req_pad[rr_next(last_q, k)]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = rr_next(last_q, k);
      end
    end
  end

endmodule

// File: rtl/pkt_drain_arbiter.sv
// Drains length-prefixed packets from three output FIFOs into one byte stream.
// Ports:
//   clock, resetn           clock, synchronous active-low reset
//   vld_out_n, data_out_n   FIFO n not-empty flag and read data (one cycle after read)
//   out_ready               sink can take a byte
//   read_enb_n              FIFO n read strobe
//   pkt_data/vld/sop/eop    merged stream, sop on header, eop on parity byte
//   grant                   port being drained, 2'b11 when none
//   abort                   one-cycle pulse when a packet is dropped after a stall
module pkt_drain_arbiter
  import pkt_drain_arbiter_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  input  logic       out_ready,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] pkt_data,
  output logic       pkt_vld,
  output logic       pkt_sop,
  output logic       pkt_eop,
  output logic [1:0] grant,
  output logic       abort
);

  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [6:0]        remaining_q, remaining_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic              hdr_pending_q, hdr_pending_d;
  logic              rd_vld_q;
  logic [1:0]        rd_port_q;
  logic              rd_sop_q, rd_sop_d;
  logic              rd_eop_q, rd_eop_d;

  logic [3:0] vld_vec;
  logic       vld_g, reading, rd_en;
  logic [7:0] data_mux;
  logic [6:0] rem_eff;
  logic       arb_vld, rr_update;
  logic [1:0] arb_idx;

  rr_arbiter3 u_rr (
    .clk_i        (clock),
    .rst_ni       (resetn),
    .req_i        ({vld_out_2, vld_out_1, vld_out_0}),
    .update_i     (rr_update),
    .update_idx_i (grant_q),
    .gnt_vld_o    (arb_vld),
    .gnt_idx_o    (arb_idx)
  );

  // grant_q is GRANT_NONE outside a packet, which selects the constant-0 slot.
  assign vld_vec = {1'b0, vld_out_2, vld_out_1, vld_out_0};
  assign vld_g   = vld_vec[grant_q];
  assign reading = state_q inside {StRdHdr, StRdBody};
  assign rd_en   = reading & vld_g & out_ready;

  assign read_enb_0 = rd_en & (grant_q == 2'd0);
  assign read_enb_1 = rd_en & (grant_q == 2'd1);
  assign read_enb_2 = rd_en & (grant_q == 2'd2);

  always_comb begin
    unique case (rd_port_q)
      2'd0:    data_mux = data_out_0;
      2'd1:    data_mux = data_out_1;
      default: data_mux = data_out_2;
    endcase
  end

  assign pkt_data = rd_vld_q ? data_mux : 8'h00;
  assign pkt_vld  = rd_vld_q;
  assign pkt_sop  = rd_vld_q & rd_sop_q;
  assign pkt_eop  = rd_vld_q & rd_eop_q;
  assign grant    = grant_q;
  assign abort    = (state_q == StAbort);

  // While the header byte is on pkt_data the count comes straight from it, so a
  // body read in that same cycle still decrements the right value.
  assign rem_eff = hdr_pending_q ? ({1'b0, pkt_data[LEN_MSB:LEN_LSB]} + 7'd1) : remaining_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    remaining_d   = remaining_q;
    stall_d       = stall_q;
    hdr_pending_d = 1'b0;
    rd_sop_d      = 1'b0;
    rd_eop_d      = 1'b0;
    rr_update     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_vld) begin
          grant_d = arb_idx;
          stall_d = '0;
          state_d = StRdHdr;
        end
      end
      StRdHdr: begin
        if (rd_en) begin
          rd_sop_d      = 1'b1;
          hdr_pending_d = 1'b1;
          state_d       = StRdBody;
        end
      end
      StRdBody: begin
        remaining_d = rem_eff;
        if (rd_en) begin
          remaining_d = rem_eff - 7'd1;
          if (rem_eff == 7'd1) begin
            rd_eop_d = 1'b1;
            state_d  = StFlush;
          end
        end
      end
      StFlush, StAbort: begin
        rr_update   = 1'b1;
        grant_d     = GRANT_NONE;
        remaining_d = '0;
        stall_d     = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Only an empty source FIFO counts as a stall; sink backpressure does not.
    if (reading) begin
      if (rd_en) begin
        stall_d = '0;
      end else if (!vld_g) begin
        if (32'(stall_q) + 32'd1 >= STALL_LIMIT) begin
          stall_d = '0;
          state_d = StAbort;
        end else begin
          stall_d = stall_q + StallW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= StIdle;
      grant_q       <= GRANT_NONE;
      remaining_q   <= '0;
      stall_q       <= '0;
      hdr_pending_q <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_port_q     <= 2'd0;
      rd_sop_q      <= 1'b0;
      rd_eop_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      remaining_q   <= remaining_d;
      stall_q       <= stall_d;
      hdr_pending_q <= hdr_pending_d;
      rd_vld_q      <= rd_en;
      if (rd_en) begin
        rd_port_q <= grant_q;
      end
      rd_sop_q      <= rd_sop_d;
      rd_eop_q      <= rd_eop_d;
    end
  end

endmodule

// File: tb/tb_pkt_drain_arbiter.sv
// Self-checking bench for pkt_drain_arbiter: FIFO models feed the three ports,
// a monitor records the merged stream, and a round-robin packet model predicts it.
module tb_pkt_drain_arbiter;

  localparam int unsigned STALL = 16;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vld_out_0 = 1'b0, vld_out_1 = 1'b0, vld_out_2 = 1'b0;
  logic [7:0] data_out_0 = 8'h00, data_out_1 = 8'h00, data_out_2 = 8'h00;
  logic       out_ready = 1'b1;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] pkt_data;
  logic       pkt_vld, pkt_sop, pkt_eop, abort;
  logic [1:0] grant;

  pkt_drain_arbiter #(.STALL_LIMIT(STALL)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .out_ready  (out_ready),
    .read_enb_0 (read_enb_0),
    .read_enb_1 (read_enb_1),
    .read_enb_2 (read_enb_2),
    .pkt_data   (pkt_data),
    .pkt_vld    (pkt_vld),
    .pkt_sop    (pkt_sop),
    .pkt_eop    (pkt_eop),
    .grant      (grant),
    .abort      (abort)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // ---------------- FIFO models ----------------
  logic [7:0] fq0[$], fq1[$], fq2[$];
  logic [2:0] fifo_re;

  function automatic void fifo_push(int p, logic [7:0] b);
    case (p)
      0:       fq0.push_back(b);
      1:       fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
  endfunction

  function automatic logic [7:0] fifo_pop(int p);
    logic [7:0] b;
    b = 8'h00;
    case (p)
      0:       if (fq0.size() > 0) b = fq0.pop_front();
      1:       if (fq1.size() > 0) b = fq1.pop_front();
      default: if (fq2.size() > 0) b = fq2.pop_front();
    endcase
    return b;
  endfunction

  function automatic void refresh_vld();
    vld_out_0 = (fq0.size() != 0);
    vld_out_1 = (fq1.size() != 0);
    vld_out_2 = (fq2.size() != 0);
  endfunction

  function automatic void clear_fifos();
    fq0.delete();
    fq1.delete();
    fq2.delete();
    refresh_vld();
  endfunction

  // Read strobe sampled at the edge; data appears shortly after for the next cycle.
  always @(posedge clock) begin
    fifo_re = {read_enb_2, read_enb_1, read_enb_0};
    #1;
    if (fifo_re[0] === 1'b1) data_out_0 = fifo_pop(0);
    if (fifo_re[1] === 1'b1) data_out_1 = fifo_pop(1);
    if (fifo_re[2] === 1'b1) data_out_2 = fifo_pop(2);
    refresh_vld();
  end

  // ---------------- Monitor ----------------
  int         cycle = 0;
  logic [7:0] obs_data[$];
  logic       obs_sop[$], obs_eop[$];
  logic [1:0] obs_grant[$];
  int         obs_cyc[$];
  int         abort_cnt = 0, abort_cyc = 0, last_rd_cyc = 0, multi_rd = 0, rd_busy = 0;
  logic [1:0] grant_after_abort = 2'b00;
  bit         grant_chk = 1'b0;

  always @(negedge clock) begin
    cycle++;
    if (pkt_vld === 1'b1) begin
      obs_data.push_back(pkt_data);
      obs_sop.push_back(pkt_sop);
      obs_eop.push_back(pkt_eop);
      obs_grant.push_back(grant);
      obs_cyc.push_back(cycle);
    end
    if (grant_chk) begin
      grant_after_abort = grant;
      grant_chk = 1'b0;
    end
    if (abort === 1'b1) begin
      abort_cnt++;
      abort_cyc = cycle;
      grant_chk = 1'b1;
    end
    if (({read_enb_2, read_enb_1, read_enb_0} & 3'b111) != 3'b000) begin
      last_rd_cyc = cycle;
      if (out_ready === 1'b0) rd_busy++;
    end
    if ($countones({read_enb_2, read_enb_1, read_enb_0}) > 1) multi_rd++;
  end

  // ---------------- Reference model ----------------
  // Packets are listed as loaded; serving order follows round-robin over ports
  // starting after the last port that finished (or aborted).
  logic [7:0] pk_bytes[$];
  int         pk_port[$], pk_off[$], pk_n[$];
  bit         pk_done[$];
  int         rr_last = 2;
  logic [7:0] exp_data[$];
  logic       exp_sop[$], exp_eop[$];
  logic [1:0] exp_port[$];

  task automatic load_pkt(input int p, input logic [7:0] hdr, input int nload,
                          input bit to_model);
    logic [7:0] b, par;
    int len, off;
    len = int'(hdr[7:2]);
    off = pk_bytes.size();
    par = hdr;
    if (nload > 0) fifo_push(p, hdr);
    if (to_model) pk_bytes.push_back(hdr);
    for (int i = 1; i <= len; i++) begin
      b = 8'($urandom);
      par ^= b;
      if (i < nload) fifo_push(p, b);
      if (to_model) pk_bytes.push_back(b);
    end
    if (len + 1 < nload) fifo_push(p, par);
    if (to_model) begin
      pk_bytes.push_back(par);
      pk_port.push_back(p);
      pk_off.push_back(off);
      pk_n.push_back(len + 2);
      pk_done.push_back(1'b0);
    end
    refresh_vld();
  endtask

  task automatic model_expect();
    bit found;
    int p;
    exp_data.delete();
    exp_sop.delete();
    exp_eop.delete();
    exp_port.delete();
    do begin
      found = 1'b0;
      for (int k = 1; k <= 3 && !found; k++) begin
        p = (rr_last + k) % 3;
        for (int i = 0; i < pk_port.size() && !found; i++) begin
          if (!pk_done[i] && pk_port[i] == p) begin
            for (int j = 0; j < pk_n[i]; j++) begin
              exp_data.push_back(pk_bytes[pk_off[i] + j]);
              exp_sop.push_back(j == 0);
              exp_eop.push_back(j == pk_n[i] - 1);
              exp_port.push_back(2'(p));
            end
            pk_done[i] = 1'b1;
            rr_last = p;
            found = 1'b1;
          end
        end
      end
    end while (found);
  endtask

  // ---------------- Utilities ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic settle(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_sop.delete();
    obs_eop.delete();
    obs_grant.delete();
    obs_cyc.delete();
    abort_cnt = 0;
  endtask

  // Bounded wait; the caller's byte-count comparison catches an expired budget.
  task automatic wait_bytes(input int n, input int budget, input bit rnd);
    int c;
    c = 0;
    while (obs_data.size() < n && c < budget) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      step();
      c++;
    end
    out_ready = 1'b1;
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    out_ready = 1'b1;
    clear_fifos();
    step();
    step();
    total++;
    if (grant !== 2'b11) begin
      bad++; $display("FAIL reset grant: got %b want 11", grant);
    end
    total++;
    if ({read_enb_2, read_enb_1, read_enb_0} !== 3'b000) begin
      bad++; $display("FAIL reset read_enb: got %b want 000", {read_enb_2, read_enb_1, read_enb_0});
    end
    total++;
    if ({pkt_vld, pkt_sop, pkt_eop, abort} !== 4'b0000) begin
      bad++; $display("FAIL reset flags: got %b want 0000", {pkt_vld, pkt_sop, pkt_eop, abort});
    end
    total++;
    if (pkt_data !== 8'h00) begin
      bad++; $display("FAIL reset pkt_data: got %h want 00", pkt_data);
    end
    resetn = 1'b1;
    rr_last = 2;
    step();
  endtask

  task automatic test_single();
    clear_obs();
    load_pkt(1, 8'h0D, 100, 1'b1);
    model_expect();
    wait_bytes(exp_data.size(), 60, 1'b0);
    settle(3);
    total++;
    if (obs_data.size() != 5) begin
      bad++; $display("FAIL single count: got %0d want 5", obs_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      total++;
      if ({obs_data[i], obs_sop[i], obs_eop[i], obs_grant[i]} !==
          {exp_data[i], exp_sop[i], exp_eop[i], exp_port[i]}) begin
        bad++;
        $display("FAIL single byte %0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, obs_data[i],
                 obs_sop[i], obs_eop[i], obs_grant[i], exp_data[i], exp_sop[i], exp_eop[i],
                 exp_port[i]);
      end
      if (i > 0) begin
        total++;
        if (obs_cyc[i] != obs_cyc[0] + i) begin
          bad++; $display("FAIL single gap %0d: got cycle %0d want %0d", i, obs_cyc[i],
                          obs_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_all_three();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    rr_last = 2;
    clear_obs();
    load_pkt(2, {6'd1, 2'($urandom_range(0, 3))}, 100, 1'b1);
    load_pkt(1, {6'd1, 2'($urandom_range(0, 3))}, 100, 1'b1);
    load_pkt(0, {6'd1, 2'($urandom_range(0, 3))}, 100, 1'b1);
    model_expect();
    wait_bytes(exp_data.size(), 100, 1'b0);
    settle(3);
    total++;
    if (obs_data.size() != exp_data.size()) begin
      bad++; $display("FAIL three count: got %0d want %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      total++;
      if ({obs_data[i], obs_sop[i], obs_eop[i], obs_grant[i]} !==
          {exp_data[i], exp_sop[i], exp_eop[i], exp_port[i]}) begin
        bad++;
        $display("FAIL three byte %0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, obs_data[i],
                 obs_sop[i], obs_eop[i], obs_grant[i], exp_data[i], exp_sop[i], exp_eop[i],
                 exp_port[i]);
      end
      // eop byte, then FLUSH is over, one IDLE cycle, a header read: next sop 3 later.
      if (i > 0 && exp_sop[i]) begin
        total++;
        if (obs_cyc[i] - obs_cyc[i-1] > 3) begin
          bad++; $display("FAIL three packet gap at %0d: got %0d cycles want <=3", i,
                          obs_cyc[i] - obs_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_ready_stall();
    int busy0;
    busy0 = rd_busy;
    clear_obs();
    load_pkt(0, {6'd6, 2'b01}, 100, 1'b1);
    model_expect();
    wait_bytes(3, 40, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b1;
    wait_bytes(exp_data.size(), 60, 1'b0);
    settle(3);
    total++;
    if (obs_data.size() != exp_data.size()) begin
      bad++; $display("FAIL ready count: got %0d want %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      total++;
      if ({obs_data[i], obs_sop[i], obs_eop[i], obs_grant[i]} !==
          {exp_data[i], exp_sop[i], exp_eop[i], exp_port[i]}) begin
        bad++;
        $display("FAIL ready byte %0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, obs_data[i],
                 obs_sop[i], obs_eop[i], obs_grant[i], exp_data[i], exp_sop[i], exp_eop[i],
                 exp_port[i]);
      end
    end
    total++;
    if (rd_busy != busy0) begin
      bad++; $display("FAIL ready reads while not ready: got %0d want 0", rd_busy - busy0);
    end
    total++;
    if (abort_cnt != 0) begin
      bad++; $display("FAIL ready abort: got %0d pulses want 0", abort_cnt);
    end
  endtask

  task automatic test_abort();
    int c;
    clear_obs();
    // Six-byte packet on port 2, but only two bytes ever arrive in the FIFO.
    load_pkt(2, {6'd4, 2'b10}, 2, 1'b0);
    c = 0;
    while (abort_cnt == 0 && c < 80) begin
      step();
      c++;
    end
    settle(3);
    total++;
    if (abort_cnt != 1) begin
      bad++; $display("FAIL abort pulses: got %0d want 1", abort_cnt);
    end
    // Sixteen empty cycles after the last read, then the abort cycle.
    total++;
    if (abort_cyc - last_rd_cyc != STALL + 1) begin
      bad++; $display("FAIL abort timing: got %0d want %0d", abort_cyc - last_rd_cyc, STALL + 1);
    end
    total++;
    if (obs_data.size() != 2) begin
      bad++; $display("FAIL abort bytes: got %0d want 2", obs_data.size());
    end
    for (int i = 0; i < obs_data.size(); i++) begin
      total++;
      if (obs_eop[i] !== 1'b0) begin
        bad++; $display("FAIL abort eop on byte %0d: got 1 want 0", i);
      end
    end
    total++;
    if (grant_after_abort !== 2'b11) begin
      bad++; $display("FAIL abort next grant: got %b want 11", grant_after_abort);
    end
    rr_last = 2;
  endtask

  task automatic test_zero_len();
    clear_obs();
    load_pkt(0, 8'h00, 100, 1'b1);
    model_expect();
    wait_bytes(exp_data.size(), 40, 1'b0);
    settle(3);
    total++;
    if (obs_data.size() != 2) begin
      bad++; $display("FAIL zero count: got %0d want 2", obs_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      total++;
      if ({obs_data[i], obs_sop[i], obs_eop[i], obs_grant[i]} !==
          {exp_data[i], exp_sop[i], exp_eop[i], exp_port[i]}) begin
        bad++;
        $display("FAIL zero byte %0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, obs_data[i],
                 obs_sop[i], obs_eop[i], obs_grant[i], exp_data[i], exp_sop[i], exp_eop[i],
                 exp_port[i]);
      end
    end
    if (obs_cyc.size() == 2) begin
      total++;
      if (obs_cyc[1] != obs_cyc[0] + 1) begin
        bad++; $display("FAIL zero spacing: got %0d want 1", obs_cyc[1] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    load_pkt(1, {6'd8, 2'b01}, 100, 1'b0);
    wait_bytes(3, 40, 1'b0);
    resetn = 1'b0;
    step();
    total++;
    if ({grant, read_enb_2, read_enb_1, read_enb_0} !== 5'b11000) begin
      bad++; $display("FAIL midreset grant/read: got %b want 11000",
                      {grant, read_enb_2, read_enb_1, read_enb_0});
    end
    total++;
    if ({pkt_vld, pkt_sop, pkt_eop, abort, pkt_data} !== 12'h000) begin
      bad++; $display("FAIL midreset outputs: got %h want 000",
                      {pkt_vld, pkt_sop, pkt_eop, abort, pkt_data});
    end
    resetn = 1'b1;
    rr_last = 2;
    clear_fifos();
    step();
    total++;
    if (abort_cnt != 0 || obs_eop.sum() with (int'(item)) != 0) begin
      bad++; $display("FAIL midreset leftovers: got abort=%0d eop seen want none", abort_cnt);
    end
    clear_obs();
    load_pkt(2, {6'd2, 2'b11}, 100, 1'b1);
    load_pkt(0, {6'd3, 2'b00}, 100, 1'b1);
    model_expect();
    wait_bytes(exp_data.size(), 80, 1'b0);
    settle(3);
    total++;
    if (obs_data.size() != exp_data.size()) begin
      bad++; $display("FAIL midreset count: got %0d want %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      total++;
      if ({obs_data[i], obs_sop[i], obs_eop[i], obs_grant[i]} !==
          {exp_data[i], exp_sop[i], exp_eop[i], exp_port[i]}) begin
        bad++;
        $display("FAIL midreset byte %0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, obs_data[i],
                 obs_sop[i], obs_eop[i], obs_grant[i], exp_data[i], exp_sop[i], exp_eop[i],
                 exp_port[i]);
      end
    end
  endtask

  task automatic test_random();
    int np;
    for (int r = 0; r < 6; r++) begin
      clear_obs();
      for (int p = 0; p < 3; p++) begin
        np = $urandom_range(0, 2);
        for (int k = 0; k < np; k++) begin
          load_pkt(p, {6'($urandom_range(0, 12)), 2'($urandom_range(0, 3))}, 100, 1'b1);
        end
      end
      model_expect();
      wait_bytes(exp_data.size(), 4 * exp_data.size() + 100, 1'b1);
      settle(4);
      total++;
      if (obs_data.size() != exp_data.size()) begin
        bad++; $display("FAIL random round %0d count: got %0d want %0d", r, obs_data.size(),
                        exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
        total++;
        if ({obs_data[i], obs_sop[i], obs_eop[i], obs_grant[i]} !==
            {exp_data[i], exp_sop[i], exp_eop[i], exp_port[i]}) begin
          bad++;
          $display("FAIL random r%0d byte %0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", r, i,
                   obs_data[i], obs_sop[i], obs_eop[i], obs_grant[i], exp_data[i], exp_sop[i],
                   exp_eop[i], exp_port[i]);
        end
      end
      total++;
      if (abort_cnt != 0) begin
        bad++; $display("FAIL random round %0d abort: got %0d want 0", r, abort_cnt);
      end
    end
  endtask

  task automatic test_protocol();
    total++;
    if (multi_rd != 0) begin
      bad++; $display("FAIL protocol multiple read_enb: got %0d cycles want 0", multi_rd);
    end
    total++;
    if (rd_busy != 0) begin
      bad++; $display("FAIL protocol read while not ready: got %0d cycles want 0", rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_ready_stall();
    test_abort();
    test_zero_len();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_drain_arbiter.md
PKT_DRAIN_ARBITER -- requirements
Module: pkt_drain_arbiter

Interface
REQ-001 Parameter: STALL_LIMIT, 16, consecutive stalled cycles mid-packet before abort.
REQ-002 Port: clock  input  1  single clock; all logic on rising edge.
REQ-003 Port: resetn  input  1  reset, synchronous, active-low.
REQ-004 Port: vld_out_0/1/2  input  1 each  output-FIFO n not empty.
REQ-005 Port: data_out_0/1/2  input  8 each  output-FIFO n read data; valid one cycle after read_enb_n.
REQ-006 Port: out_ready  input  1  downstream sink can accept a byte.
REQ-007 Port: read_enb_0/1/2  output  1 each  FIFO n read strobe.
REQ-008 Port: pkt_data  output  8  merged packet byte.
REQ-009 Port: pkt_vld  output  1  pkt_data valid this cycle.
REQ-010 Port: pkt_sop / pkt_eop  output  1 each  first (header) / last (parity) byte marker, qualified by pkt_vld.
REQ-011 Port: grant  output  2  granted port 0..2; 2'b11 = none.
REQ-012 Port: abort  output  1  one-cycle pulse on stalled-packet abort.

Function
REQ-013 Packet format SHALL be: header byte (bits[7:2] = payload length L, 0..63; bits[1:0] = address), L payload bytes, 1 parity byte; total L+2 bytes.
REQ-014 States SHALL be IDLE, RD_HDR, RD_BODY, FLUSH, ABORT.
REQ-015 IDLE: if any vld_out_n high, grant SHALL go to the first requester in round-robin order starting after the last granted port; next state RD_HDR; grant latched until packet end or abort.
REQ-016 Read rule: read_enb_g SHALL be high only when state is RD_HDR or RD_BODY, vld_out_g high, out_ready high; all other read_enb low; at most one read_enb high per cycle.
REQ-017 Latency: each read issued in cycle N SHALL produce pkt_vld=1 with pkt_data=data_out_g in cycle N+1; the sink absorbs one in-flight byte after dropping out_ready.
REQ-018 RD_HDR: on the header read, go to RD_BODY; in the following cycle capture L from pkt_data[7:2] and load remaining = L+1; pkt_sop=1 with that byte.
REQ-019 RD_BODY: decrement remaining per read; the read that makes remaining 0 SHALL move to FLUSH; the byte it produces carries pkt_eop=1.
REQ-020 Header load and first body read in the same cycle SHALL compute remaining = L+1-1 from the header byte directly (no lost count).
REQ-021 FLUSH: one cycle for the last byte to emerge, then IDLE; round-robin pointer updated to the granted port.
REQ-022 Stall counter: in RD_HDR/RD_BODY, counts cycles with vld_out_g low (out_ready low does not count); cleared on any read; reaching STALL_LIMIT SHALL enter ABORT.
REQ-023 ABORT: one cycle, abort=1, no read, pkt_eop not asserted, pointer advanced past granted port, then IDLE.
REQ-024 L=0 SHALL yield exactly 2 bytes (sop on header, eop on parity).
REQ-025 Simultaneous requests on all ports SHALL be served 0,1,2,0,... from reset.
REQ-026 grant SHALL be 2'b11 in IDLE and ABORT's following IDLE cycle unless re-granted.

Reset
REQ-027 With resetn low at a clock edge: state IDLE, grant 2'b11, all read_enb 0, pkt_vld/sop/eop/abort 0, pkt_data 8'h00, counters 0, pointer such that port 0 wins first.
REQ-028 Reset mid-packet SHALL discard the packet with no eop and no abort pulse.

Structure
REQ-029 Shared package holds state enum, GRANT_NONE = 2'b11, N_PORTS = 3, LEN_MSB/LEN_LSB field positions.
REQ-030 One sub-module rr_arbiter3 (3-request round-robin, pointer update input) is natural; counters and FSM stay in the top.

Verification
REQ-031 Port 1 holds header 8'h0D (L=3), out_ready=1 -> 5 bytes on pkt_data consecutively, sop on first, eop on fifth, grant=1 throughout.
REQ-032 All three ports hold L=1 packets at once -> packets emerge port 0, 1, 2 in order, no gaps exceeding FLUSH+IDLE cycles.
REQ-033 out_ready low for 4 cycles mid-packet -> no read_enb during stall, one in-flight byte accepted, stream resumes, no abort.
REQ-034 Port 2 vld_out drops after 2 of 6 bytes for 16 cycles -> abort pulse at cycle 16, no eop, grant 2'b11 next.
REQ-035 Header 8'h00 on port 0 -> exactly 2 bytes, sop and eop on consecutive pkt_vld cycles.
REQ-036 resetn low during RD_BODY -> next cycle all outputs at reset values; next packet starts from port 0 priority.
